// File: rtl/clk_gen_tune_ctrl_if.sv
// Configuration, oscillator-tick and status bundle between the calibration
// controller (slave) and its driver / tunable oscillator loop (master).
interface clk_gen_tune_ctrl_if #(
    parameter int unsigned SEL_W = 4,
    parameter int unsigned CNT_W = 12,
    parameter int unsigned WIN_W = 10
);
    logic             start_in;
    logic             track_in;
    logic [SEL_W-1:0] init_sel_in;
    logic [CNT_W-1:0] target_in;
    logic [WIN_W-1:0] window_in;
    logic             osc_tick_in;
    logic [SEL_W-1:0] stage_sel_out;
    logic             busy_out;
    logic             done_out;
    logic             locked_out;
    logic             err_out;
    logic [CNT_W-1:0] count_out;

    modport slave (
        input  start_in, track_in, init_sel_in, target_in, window_in, osc_tick_in,
        output stage_sel_out, busy_out, done_out, locked_out, err_out, count_out
    );

    modport master (
        output start_in, track_in, init_sel_in, target_in, window_in, osc_tick_in,
        input  stage_sel_out, busy_out, done_out, locked_out, err_out, count_out
    );
endinterface

// File: rtl/clk_gen_tune_ctrl.sv
// Ring-oscillator calibration: settle, count ticks over a window, compare to
// target and step the delay-line code until within tolerance (one-shot or tracking).
module clk_gen_tune_ctrl #(
    parameter int unsigned NUM_STAGES    = 16,
    parameter int unsigned CNT_W         = 12,
    parameter int unsigned WIN_W         = 10,
    parameter int unsigned TOL           = 1,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned MAX_ITER      = 32
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    clk_gen_tune_ctrl_if.slave   bus
);
    localparam int unsigned SEL_W  = $clog2(NUM_STAGES);
    localparam int unsigned SET_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int unsigned ITER_W = $clog2(MAX_ITER + 1);

    localparam logic [SEL_W-1:0]        SEL_MAX = SEL_W'(NUM_STAGES - 1);
    localparam logic signed [CNT_W:0]   TOL_POS = (CNT_W + 1)'(TOL);
    localparam logic signed [CNT_W:0]   TOL_NEG = -TOL_POS;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_MEASURE,
        ST_EVAL,
        ST_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [CNT_W-1:0]   target_q, target_d;
    logic [CNT_W-1:0]   tick_q, tick_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [WIN_W-1:0]   window_q, window_d;
    logic [WIN_W-1:0]   win_cnt_q, win_cnt_d;
    logic [SET_W-1:0]   settle_q, settle_d;
    logic [ITER_W-1:0]  iter_q, iter_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               locked_q, locked_d;
    logic               err_q, err_d;

    logic signed [CNT_W:0] diff_c;
    logic [ITER_W-1:0]     iter_inc_c;
    logic [SEL_W-1:0]      init_sel_c;
    logic [WIN_W-1:0]      win_eff_c;

    // Signed error one bit wider than the count so both directions are representable.
    assign diff_c     = $signed({1'b0, tick_q}) - $signed({1'b0, target_q});
    assign iter_inc_c = iter_q + ITER_W'(1);
    assign init_sel_c = ({1'b0, bus.init_sel_in} >= (SEL_W + 1)'(NUM_STAGES)) ? SEL_MAX
                                                                              : bus.init_sel_in;
    assign win_eff_c  = (bus.window_in == '0) ? WIN_W'(1) : bus.window_in;

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        target_d  = target_q;
        tick_d    = tick_q;
        count_d   = count_q;
        window_d  = window_q;
        win_cnt_d = win_cnt_q;
        settle_d  = settle_q;
        iter_d    = iter_q;
        done_d    = 1'b0;
        locked_d  = locked_q;
        err_d     = err_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start_in) begin
                    sel_d    = init_sel_c;
                    target_d = bus.target_in;
                    window_d = win_eff_c;
                    iter_d   = '0;
                    locked_d = 1'b0;
                    err_d    = 1'b0;
                    settle_d = '0;
                    state_d  = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (settle_q == SET_W'(SETTLE_CYCLES - 1)) begin
                    win_cnt_d = '0;
                    tick_d    = '0;
                    state_d   = ST_MEASURE;
                end else begin
                    settle_d = settle_q + SET_W'(1);
                end
            end
            ST_MEASURE: begin
                if (bus.osc_tick_in && (tick_q != '1)) begin
                    tick_d = tick_q + CNT_W'(1);
                end
                if (win_cnt_q == window_q - WIN_W'(1)) begin
                    state_d = ST_EVAL;
                end else begin
                    win_cnt_d = win_cnt_q + WIN_W'(1);
                end
            end
            ST_EVAL: begin
                count_d  = tick_q;
                settle_d = '0;
                if ((diff_c <= TOL_POS) && (diff_c >= TOL_NEG)) begin
                    locked_d = 1'b1;
                    iter_d   = '0;
                    done_d   = 1'b1;
                    state_d  = bus.track_in ? ST_SETTLE : ST_DONE;
                end else begin
                    locked_d = 1'b0;
                    iter_d   = iter_inc_c;
                    // Iteration limit wins over stepping and leaves the code untouched.
                    if (iter_inc_c == ITER_W'(MAX_ITER)) begin
                        err_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else if (diff_c > TOL_POS) begin
                        if (sel_q < SEL_MAX) begin
                            sel_d   = sel_q + SEL_W'(1);
                            state_d = ST_SETTLE;
                        end else begin
                            err_d   = 1'b1;
                            done_d  = 1'b1;
                            state_d = ST_DONE;
                        end
                    end else begin
                        if (sel_q != '0) begin
                            sel_d   = sel_q - SEL_W'(1);
                            state_d = ST_SETTLE;
                        end else begin
                            err_d   = 1'b1;
                            done_d  = 1'b1;
                            state_d = ST_DONE;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_SETTLE) || (state_d == ST_MEASURE) || (state_d == ST_EVAL);
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q   <= ST_IDLE;
            sel_q     <= '0;
            target_q  <= '0;
            tick_q    <= '0;
            count_q   <= '0;
            window_q  <= '0;
            win_cnt_q <= '0;
            settle_q  <= '0;
            iter_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            locked_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            target_q  <= target_d;
            tick_q    <= tick_d;
            count_q   <= count_d;
            window_q  <= window_d;
            win_cnt_q <= win_cnt_d;
            settle_q  <= settle_d;
            iter_q    <= iter_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            locked_q  <= locked_d;
            err_q     <= err_d;
        end
    end

    assign bus.stage_sel_out = sel_q;
    assign bus.busy_out      = busy_q;
    assign bus.done_out      = done_q;
    assign bus.locked_out    = locked_q;
    assign bus.err_out       = err_q;
    assign bus.count_out     = count_q;
endmodule

// File: tb/tb_clk_gen_tune_ctrl.sv
// Scoreboard bench for clk_gen_tune_ctrl: a behavioural oscillator model feeds
// ticks, expected done_out events are queued at start and checked by monitors.
module tb_clk_gen_tune_ctrl;
    localparam int SEL_W  = 4;
    localparam int CNT_W  = 12;
    localparam int WIN_W  = 10;
    localparam int SETTLE = 4;
    localparam int WIN    = 16;
    localparam int PER    = SETTLE + WIN + 1;

    typedef struct {
        int sel;
        int locked;
        int err;
        int busy;
        int count;
        int cyc;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   errors = 0;
    int   checks = 0;

    int   t0a  = 0;
    int   t0b  = 0;
    int   offa = 20;
    int   tgtb = 8;

    exp_t qa[$];
    exp_t qb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    clk_gen_tune_ctrl_if #(.SEL_W(SEL_W), .CNT_W(CNT_W), .WIN_W(WIN_W)) ifa ();
    clk_gen_tune_ctrl_if #(.SEL_W(SEL_W), .CNT_W(CNT_W), .WIN_W(WIN_W)) ifb ();

    clk_gen_tune_ctrl #(
        .NUM_STAGES(16), .CNT_W(CNT_W), .WIN_W(WIN_W), .TOL(0),
        .SETTLE_CYCLES(SETTLE), .MAX_ITER(32)
    ) dut_a (
        .clk_in  (clk),
        .rst_n_in(rst_n),
        .bus     (ifa.slave)
    );

    clk_gen_tune_ctrl #(
        .NUM_STAGES(16), .CNT_W(CNT_W), .WIN_W(WIN_W), .TOL(0),
        .SETTLE_CYCLES(SETTLE), .MAX_ITER(8)
    ) dut_b (
        .clk_in  (clk),
        .rst_n_in(rst_n),
        .bus     (ifb.slave)
    );

    function automatic exp_t mk(int sel, int locked, int err, int busy, int count, int c);
        exp_t e;
        e.sel = sel; e.locked = locked; e.err = err; e.busy = busy; e.count = count; e.cyc = c;
        return e;
    endfunction

    function automatic void chk(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // Oscillator model: N ticks at the start of each measurement window, N from the code.
    always @(negedge clk) begin
        int p;
        int q;
        int na;
        int nb;
        na = offa - int'(ifa.stage_sel_out);
        if (na > WIN) na = WIN;
        ifa.osc_tick_in = 1'b0;
        p = cyc - t0a - 1;
        if (p >= 0) begin
            q = p % PER;
            if (q >= SETTLE && (q - SETTLE) < na) ifa.osc_tick_in = 1'b1;
        end
        nb = ifb.stage_sel_out[0] ? tgtb - 5 : tgtb + 5;
        ifb.osc_tick_in = 1'b0;
        p = cyc - t0b - 1;
        if (p >= 0) begin
            q = p % PER;
            if (q >= SETTLE && (q - SETTLE) < nb) ifb.osc_tick_in = 1'b1;
        end
    end

    // Monitor for instance A.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && ifa.done_out) begin
            if (qa.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_unexpected_done: got done_out=1 at cycle %0d, required no event", cyc);
            end else begin
                e = qa.pop_front();
                chk("a_sel",    int'(ifa.stage_sel_out), e.sel);
                chk("a_locked", int'(ifa.locked_out),    e.locked);
                chk("a_err",    int'(ifa.err_out),       e.err);
                chk("a_busy",   int'(ifa.busy_out),      e.busy);
                chk("a_count",  int'(ifa.count_out),     e.count);
                chk("a_cycle",  cyc,                     e.cyc);
            end
        end
    end

    // Monitor for instance B.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && ifb.done_out) begin
            if (qb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_unexpected_done: got done_out=1 at cycle %0d, required no event", cyc);
            end else begin
                e = qb.pop_front();
                chk("b_sel",    int'(ifb.stage_sel_out), e.sel);
                chk("b_locked", int'(ifb.locked_out),    e.locked);
                chk("b_err",    int'(ifb.err_out),       e.err);
                chk("b_busy",   int'(ifb.busy_out),      e.busy);
                chk("b_count",  int'(ifb.count_out),     e.count);
                chk("b_cycle",  cyc,                     e.cyc);
            end
        end
    end

    task automatic check_zero_a(string tag);
        chk({tag, "_sel"},    int'(ifa.stage_sel_out), 0);
        chk({tag, "_busy"},   int'(ifa.busy_out),      0);
        chk({tag, "_done"},   int'(ifa.done_out),      0);
        chk({tag, "_locked"}, int'(ifa.locked_out),    0);
        chk({tag, "_err"},    int'(ifa.err_out),       0);
        chk({tag, "_count"},  int'(ifa.count_out),     0);
    endtask

    task automatic start_a(input int init, input int tgt, input logic trk);
        @(negedge clk);
        ifa.init_sel_in = SEL_W'(init);
        ifa.target_in   = CNT_W'(tgt);
        ifa.window_in   = WIN_W'(WIN);
        ifa.track_in    = trk;
        ifa.start_in    = 1'b1;
        t0a             = cyc;
        @(negedge clk);
        ifa.start_in    = 1'b0;
    endtask

    task automatic wait_done(input bit use_b, input int budget, input string tag);
        int  n;
        bit  seen;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < budget) begin
            @(negedge clk);
            n++;
            seen = use_b ? ifb.done_out : ifa.done_out;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_timeout: got done_out=0 after %0d cycles, required 1", tag, n);
        end
    endtask

    task automatic wait_cycle(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    initial begin
        ifa.start_in = 1'b0; ifa.track_in = 1'b0; ifa.init_sel_in = '0;
        ifa.target_in = '0;  ifa.window_in = '0;
        ifb.start_in = 1'b0; ifb.track_in = 1'b0; ifb.init_sel_in = '0;
        ifb.target_in = '0;  ifb.window_in = '0;

        repeat (2) @(negedge clk);
        check_zero_a("reset");
        rst_n = 1'b1;

        // Asynchronous reset in the middle of a measurement window.
        start_a(8, 12, 1'b0);
        wait_cycle(t0a + 12);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero_a("async_rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Already on target: single evaluation.
        offa = 20;
        start_a(8, 12, 1'b0);
        qa.push_back(mk(8, 1, 0, 0, 12, t0a + PER + 1));
        wait_done(1'b0, 100, "lock_init8");

        // Four downward-slowing steps, lock on the fifth evaluation.
        start_a(4, 12, 1'b0);
        qa.push_back(mk(8, 1, 0, 0, 12, t0a + 5 * PER + 1));
        wait_done(1'b0, 200, "lock_init4");

        // Saturation at the slowest code.
        start_a(0, 2, 1'b0);
        qa.push_back(mk(15, 0, 1, 0, 5, t0a + 16 * PER + 1));
        wait_done(1'b0, 400, "saturate");

        // Tracking: lock, disturbance, relock, then leave tracking.
        start_a(8, 12, 1'b1);
        qa.push_back(mk(8, 1, 0, 1, 12, t0a + PER + 1));
        qa.push_back(mk(9, 1, 0, 1, 12, t0a + 3 * PER + 1));
        qa.push_back(mk(9, 1, 0, 0, 12, t0a + 4 * PER + 1));
        wait_done(1'b0, 100, "track_lock1");
        offa = 21;
        wait_cycle(t0a + 2 * PER + 1);
        chk("track_unlock_sel",    int'(ifa.stage_sel_out), 9);
        chk("track_unlock_locked", int'(ifa.locked_out),    0);
        chk("track_unlock_busy",   int'(ifa.busy_out),      1);
        chk("track_unlock_done",   int'(ifa.done_out),      0);
        wait_done(1'b0, 100, "track_relock");
        ifa.track_in = 1'b0;
        wait_done(1'b0, 100, "track_exit");

        // Iteration limit on the MAX_ITER=8 instance, start held while busy.
        tgtb = 8;
        @(negedge clk);
        ifb.init_sel_in = SEL_W'(6);
        ifb.target_in   = CNT_W'(8);
        ifb.window_in   = WIN_W'(WIN);
        ifb.track_in    = 1'b0;
        ifb.start_in    = 1'b1;
        t0b             = cyc;
        qb.push_back(mk(7, 0, 1, 0, 3, t0b + 8 * PER + 1));
        repeat (40) @(negedge clk);
        ifb.start_in    = 1'b0;
        wait_done(1'b1, 300, "max_iter");

        repeat (4) @(negedge clk);
        chk("qa_drained", qa.size(), 0);
        chk("qb_drained", qb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
